rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: DATA_SIZE, default 32, register data width (matches codebase DATA_SIZE define).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive un-granted cycles before a stall is requested.
REQ-003 Reset reset_n, synchronous, active-low; clock clock.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 WB_dest  in  5  pipeline writeback destination register.
REQ-007 WB_value  in  DATA_SIZE  pipeline writeback data.
REQ-008 WB_WEenable  in  1  pipeline writeback valid.
REQ-009 md_valid  in  1  multi-cycle (mul/div) unit result valid.
REQ-010 md_dest  in  5  mul/div destination register.
REQ-011 md_value  in  DATA_SIZE  mul/div result data.
REQ-012 md_ready  out  1  result queue can accept; combinational, equals queue not full.
REQ-013 dbg_req  in  1  debug register-write request, level, held until acked.
REQ-014 dbg_dest  in  5  debug destination register.
REQ-015 dbg_value  in  DATA_SIZE  debug write data.
REQ-016 dbg_ack  out  1  one-cycle pulse, debug write performed.
REQ-017 rf_we  out  1  register-file write enable, registered.
REQ-018 rf_addr  out  5  register-file write address, registered.
REQ-019 rf_wdata  out  DATA_SIZE  register-file write data, registered.
REQ-020 stall_req  out  1  registered request to hold the pipeline; high only in STALL state.

Function
REQ-021 Result queue SHALL be a 2-entry FIFO; enqueue on posedge when md_valid && md_ready; entry eligible for grant from the following cycle.
REQ-022 No enqueue SHALL occur when full, even if a dequeue occurs the same cycle; simultaneous enqueue and dequeue when count is 1 SHALL leave count 1.
REQ-023 Arbitration per cycle, priority: pipeline (WB_WEenable=1) > queue head (count>0) > debug (dbg_req=1, queue empty).
REQ-024 Winner SHALL appear on rf_we/rf_addr/rf_wdata exactly one cycle after the sampling edge; no winner -> rf_we=0, rf_addr/rf_wdata hold.
REQ-025 Winning destination 0 SHALL produce rf_we=0, but the source is still consumed (queue pop, dbg_ack pulse).
REQ-026 dbg_ack SHALL pulse in the same cycle rf_we reflects the debug write; no re-grant of debug in the ack cycle.
REQ-027 FSM states: NORMAL, STALL.
REQ-028 NORMAL: starve counter increments each cycle the queue is non-empty and not granted; clears on queue grant or queue empty.
REQ-029 NORMAL -> STALL when starve counter reaches STARVE_LIMIT; stall_req=1 from the next cycle.
REQ-030 STALL: queue is granted whenever WB_WEenable=0; STALL -> NORMAL, counter cleared, on the cycle the queue becomes empty.
REQ-031 Debug SHALL never be granted in STALL.
REQ-032 Register-order hazards between pipeline and mul/div results are outside this block.

Reset
REQ-033 On reset: rf_we=0, rf_addr=0, rf_wdata=0, dbg_ack=0, stall_req=0, FSM=NORMAL, counter=0, queue emptied (md_ready=1 the next cycle).
REQ-034 Reset mid-operation SHALL discard queued results with no rf_we pulse.

Structure
REQ-035 State enum (NORMAL, STALL) and default STARVE_LIMIT SHALL live in a shared package wb_pkg; DATA_SIZE comes from defines.vh.
REQ-036 The FIFO SHALL be a sub-module rf_wr_fifo (parameterised width, depth 2, push/pop/full/empty/count).

Verification
REQ-037 WB_WEenable=1, WB_dest=5, WB_value=0xA5A5A5A5 -> next cycle rf_we=1, rf_addr=5, rf_wdata=0xA5A5A5A5.
REQ-038 md push dest=7 value=0x10 with WB idle -> rf_we=1, rf_addr=7 two cycles after push; md_ready stays 1.
REQ-039 WB_WEenable held 1 and one md entry queued -> stall_req=1 after 4 un-granted cycles; release WB -> queue written, stall_req=0 the cycle after empty.
REQ-040 Two md pushes then third md_valid -> md_ready=0, third not accepted, both entries written in order.
REQ-041 dbg_req dest=0 value=0xFF -> dbg_ack pulse, rf_we=0; dbg_req dest=3 while queue non-empty -> ack only after queue drains.
REQ-042 Reset asserted with 2 entries queued and stall_req=1 -> all outputs 0, md_ready=1, no subsequent rf_we.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// wb_pkg: definitions shared by the register-file write arbiter slice.
//   DATA_SIZE_DEF    - default register data width (codebase DATA_SIZE)
//   STARVE_LIMIT_DEF - default un-granted cycles before a stall request
//   ST_NORMAL/ST_STALL - arbiter FSM state encodings
package wb_pkg;
    localparam int DATA_SIZE_DEF    = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_STALL  = 1'b1;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: bundles the three write sources and the register-file
// write port of the arbiter.
//   WB_*          - pipeline writeback (highest priority)
//   md_*          - mul/div result handshake (md_ready = queue not full)
//   dbg_*         - debug write request, level until dbg_ack pulses
//   rf_*          - registered register-file write port
//   stall_req     - request to hold the pipeline
// master: the side driving the sources; slave: the arbiter.
interface rf_write_arbiter_if #(
    parameter int DATA_SIZE = wb_pkg::DATA_SIZE_DEF
);
    import wb_pkg::*;

    logic [4:0]           WB_dest;
    logic [DATA_SIZE-1:0] WB_value;
    logic                 WB_WEenable;
    logic                 md_valid;
    logic [4:0]           md_dest;
    logic [DATA_SIZE-1:0] md_value;
    logic                 md_ready;
    logic                 dbg_req;
    logic [4:0]           dbg_dest;
    logic [DATA_SIZE-1:0] dbg_value;
    logic                 dbg_ack;
    logic                 rf_we;
    logic [4:0]           rf_addr;
    logic [DATA_SIZE-1:0] rf_wdata;
    logic                 stall_req;

    modport master (
        output WB_dest, WB_value, WB_WEenable,
        output md_valid, md_dest, md_value,
        output dbg_req, dbg_dest, dbg_value,
        input  md_ready, dbg_ack, rf_we, rf_addr, rf_wdata, stall_req
    );

    modport slave (
        input  WB_dest, WB_value, WB_WEenable,
        input  md_valid, md_dest, md_value,
        input  dbg_req, dbg_dest, dbg_value,
        output md_ready, dbg_ack, rf_we, rf_addr, rf_wdata, stall_req
    );
endinterface

// File: rtl/rf_write_arbiter_fifo.sv
// rf_wr_fifo: 2-entry FIFO holding {dest, value} mul/div results.
//   clock, reset_n - clock, synchronous active-low reset
//   push, din      - enqueue (ignored when full)
//   pop, dout      - dequeue (ignored when empty); dout is the head entry
//   full, empty, count - occupancy
module rf_wr_fifo #(
    parameter int WIDTH = 37
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    // A full queue refuses a push even if it is popped in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: single register-file write port shared by the pipeline
// writeback, a queued mul/div result stream and a debug write port.
//   clock, reset_n - clock, synchronous active-low reset
//   bus (slave)    - sources, rf write port, md_ready, dbg_ack, stall_req
// Priority: pipeline > queue head > debug (debug only with an empty queue and
// never while stalling). A queue head starved by the pipeline for
// STARVE_LIMIT cycles raises stall_req until the queue drains.
module rf_write_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    rf_write_arbiter_if.slave bus
);
    localparam int QW = DATA_SIZE + 5;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [0:0]           state;
    logic [CW-1:0]        starve_cnt;
    logic [QW-1:0]        q_head;
    logic                 q_full, q_empty;
    logic [1:0]           q_count;
    logic                 wb_win, q_win, dbg_win, any_win;
    logic [4:0]           win_dest;
    logic [DATA_SIZE-1:0] win_value;

    rf_wr_fifo #(.WIDTH(QW)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (bus.md_valid),
        .din     ({bus.md_dest, bus.md_value}),
        .pop     (q_win),
        .dout    (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    assign bus.md_ready  = ~q_full;
    assign bus.stall_req = (state == ST_STALL);

    assign wb_win  = bus.WB_WEenable;
    assign q_win   = ~bus.WB_WEenable & (q_count != 2'd0);
    // The ack cycle blocks a second grant of the still-asserted request.
    assign dbg_win = ~bus.WB_WEenable & q_empty & bus.dbg_req &
                     (state == ST_NORMAL) & ~bus.dbg_ack;
    assign any_win = wb_win | q_win | dbg_win;

    always_comb begin
        win_dest  = bus.dbg_dest;
        win_value = bus.dbg_value;
        if (wb_win) begin
            win_dest  = bus.WB_dest;
            win_value = bus.WB_value;
        end else if (q_win) begin
            win_dest  = q_head[DATA_SIZE +: 5];
            win_value = q_head[DATA_SIZE-1:0];
        end
    end

    // Register x0 is never written, but the winning source is still consumed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_addr  <= 5'd0;
            bus.rf_wdata <= '0;
            bus.dbg_ack  <= 1'b0;
        end else begin
            bus.rf_we   <= any_win & (win_dest != 5'd0);
            bus.dbg_ack <= dbg_win;
            if (any_win) begin
                bus.rf_addr  <= win_dest;
                bus.rf_wdata <= win_value;
            end
        end
    end

    // The transition fires on the edge where the counter would reach
    // STARVE_LIMIT, so stall_req rises the cycle after the last starved one.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (q_empty || q_win) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
                        state      <= ST_STALL;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                end
                default: begin
                    starve_cnt <= '0;
                    if (q_empty) state <= ST_NORMAL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ack;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    rf_write_arbiter_if #(.DATA_SIZE(32)) bus ();

    rf_write_arbiter #(.DATA_SIZE(32), .STARVE_LIMIT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic we, input logic [4:0] a, input logic [31:0] d, input logic ack);
        ev_t e;
        e.we = we; e.addr = a; e.data = d; e.ack = ack;
        exp_q.push_back(e);
    endtask

    task automatic wb(input logic [4:0] d, input logic [31:0] v);
        bus.WB_WEenable = 1'b1; bus.WB_dest = d; bus.WB_value = v;
        expect_ev(1'b1, d, v, 1'b0);
    endtask

    task automatic md(input logic [4:0] d, input logic [31:0] v);
        bus.md_valid = 1'b1; bus.md_dest = d; bus.md_value = v;
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.dbg_ack) break;
        end
        chk(name, bus.dbg_ack, 1);
        tick();
        bus.dbg_req = 1'b0;
        @(negedge clock);
        chk({name, "_single_pulse"}, bus.dbg_ack, 0);
    endtask

    // Scoreboard monitor: every cycle with a write or an ack must match the
    // oldest expected event.
    always @(negedge clock) begin
        if (bus.rf_we || bus.dbg_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual we=%0b addr=%0d data=%h ack=%0b required=none",
                         bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.dbg_ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.rf_we !== mon_e.we || bus.dbg_ack !== mon_e.ack ||
                    (mon_e.we && (bus.rf_addr !== mon_e.addr || bus.rf_wdata !== mon_e.data))) begin
                    errors++;
                    $display("FAIL write_event actual we=%0b addr=%0d data=%h ack=%0b required we=%0b addr=%0d data=%h ack=%0b",
                             bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.dbg_ack,
                             mon_e.we, mon_e.addr, mon_e.data, mon_e.ack);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        bus.WB_WEenable = 0; bus.WB_dest = 0; bus.WB_value = 0;
        bus.md_valid = 0; bus.md_dest = 0; bus.md_value = 0;
        bus.dbg_req = 0; bus.dbg_dest = 0; bus.dbg_value = 0;
        repeat (3) tick();
        @(negedge clock);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_rf_addr", bus.rf_addr, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_dbg_ack", bus.dbg_ack, 0);
        chk("rst_stall_req", bus.stall_req, 0);
        chk("rst_md_ready", bus.md_ready, 1);
        reset_n = 1'b1;
        repeat (2) tick();

        // Pipeline write, one-cycle latency, then hold with no winner.
        wb(5'd5, 32'hA5A5A5A5);
        tick();
        bus.WB_WEenable = 1'b0;
        @(negedge clock);
        chk("wb_latency_we", bus.rf_we, 1);
        chk("wb_latency_addr", bus.rf_addr, 5);
        tick();
        @(negedge clock);
        chk("idle_we", bus.rf_we, 0);
        chk("idle_addr_hold", bus.rf_addr, 5);
        chk("idle_data_hold", bus.rf_wdata, 32'hA5A5A5A5);
        tick();

        // Single mul/div result: written two cycles after the push edge.
        md(5'd7, 32'h10);
        expect_ev(1'b1, 5'd7, 32'h10, 1'b0);
        chk("md_ready_empty", bus.md_ready, 1);
        tick();
        bus.md_valid = 1'b0;
        @(negedge clock);
        chk("md_not_yet", bus.rf_we, 0);
        chk("md_ready_one", bus.md_ready, 1);
        tick();
        @(negedge clock);
        chk("md_two_cycles_we", bus.rf_we, 1);
        chk("md_two_cycles_addr", bus.rf_addr, 7);
        repeat (3) tick();

        // Fill the queue under pipeline traffic; third result refused.
        wb(5'd1, 32'h101); md(5'd8, 32'h88); tick();
        wb(5'd2, 32'h102); md(5'd9, 32'h99); tick();
        wb(5'd3, 32'h103); md(5'd10, 32'hAA);
        chk("md_ready_full", bus.md_ready, 0);
        tick();
        bus.WB_WEenable = 1'b0; bus.md_valid = 1'b0;
        expect_ev(1'b1, 5'd8, 32'h88, 1'b0);
        expect_ev(1'b1, 5'd9, 32'h99, 1'b0);
        repeat (4) tick();
        chk("md_ready_drained", bus.md_ready, 1);

        // Starvation: stall_req after 4 un-granted cycles, drops after drain.
        wb(5'd4, 32'h200); md(5'd11, 32'hBB);
        tick();
        bus.md_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wb(5'd4, 32'h200 + i);
            @(negedge clock);
            chk($sformatf("starve_c%0d_stall", i), bus.stall_req, (i == 5) ? 1 : 0);
            tick();
        end
        bus.WB_WEenable = 1'b0;
        expect_ev(1'b1, 5'd11, 32'hBB, 1'b0);
        @(negedge clock);
        chk("stall_held_grant", bus.stall_req, 1);
        tick();
        @(negedge clock);
        chk("stall_held_empty", bus.stall_req, 1);
        tick();
        @(negedge clock);
        chk("stall_released", bus.stall_req, 0);
        repeat (2) tick();

        // Debug write to x0: ack pulse, no rf_we.
        bus.dbg_req = 1'b1; bus.dbg_dest = 5'd0; bus.dbg_value = 32'hFF;
        expect_ev(1'b0, 5'd0, 32'h0, 1'b1);
        wait_ack("dbg_x0_ack");
        tick();

        // Debug waits for queued results to drain.
        md(5'd12, 32'hCC);
        expect_ev(1'b1, 5'd12, 32'hCC, 1'b0);
        tick();
        md(5'd13, 32'hDD);
        expect_ev(1'b1, 5'd13, 32'hDD, 1'b0);
        bus.dbg_req = 1'b1; bus.dbg_dest = 5'd3; bus.dbg_value = 32'h33;
        expect_ev(1'b1, 5'd3, 32'h33, 1'b1);
        tick();
        bus.md_valid = 1'b0;
        wait_ack("dbg_after_drain_ack");
        repeat (2) tick();

        // Reset while stalled with two entries queued.
        wb(5'd20, 32'h300); md(5'd14, 32'hEE); tick();
        wb(5'd20, 32'h301); md(5'd15, 32'hFF); tick();
        bus.md_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wb(5'd20, 32'h302 + i);
            @(negedge clock);
            if (bus.stall_req) break;
            tick();
        end
        chk("stall_before_reset", bus.stall_req, 1);
        tick();
        reset_n = 1'b0;
        bus.WB_WEenable = 1'b0;
        tick();
        @(negedge clock);
        chk("mid_rst_rf_we", bus.rf_we, 0);
        chk("mid_rst_rf_addr", bus.rf_addr, 0);
        chk("mid_rst_rf_wdata", bus.rf_wdata, 0);
        chk("mid_rst_dbg_ack", bus.dbg_ack, 0);
        chk("mid_rst_stall_req", bus.stall_req, 0);
        chk("mid_rst_md_ready", bus.md_ready, 1);
        reset_n = 1'b1;
        repeat (10) tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
